// File: rtl/uart_transceiver.sv
// Full-duplex UART with valid/ready byte ports, start/stop framing and RX error pulses.
// Optional even parity bit when UART_PARITY_EN is defined; otherwise no parity bit.
module uart_transceiver #(
    parameter int CLK_DIV   = 10416,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din,
    output logic                 dout,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_par_err,
    output logic                 rx_overrun
);
    // Handshakes: a byte moves on any posedge where valid && ready; valid holds until then.
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                tx_state, tx_state_n;
    logic [CW-1:0]         tx_cnt, tx_cnt_n;
    logic [2:0]            tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0]  tx_buf;
    logic                  tx_load, tx_end;

    assign tx_end   = (tx_cnt == BIT_LAST);
    assign tx_ready = (tx_state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_buf   <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            if (tx_load) tx_buf <= tx_data;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_load    = 1'b0;
        dout       = 1'b1;
        if (tx_state != IDLE) tx_cnt_n = tx_end ? '0 : tx_cnt + 1'b1;
        case (tx_state)
            IDLE: if (tx_valid) begin
                tx_load    = 1'b1;
                tx_state_n = START;
                tx_cnt_n   = '0;
                tx_bit_n   = '0;
            end
            START: begin
                dout = 1'b0;
                if (tx_end) tx_state_n = DATA;
            end
            DATA: begin
                dout = tx_buf[tx_bit];
                if (tx_end) begin
                    tx_bit_n = tx_bit + 1'b1;
                    if (tx_bit == DATA_LAST) begin
                        tx_bit_n = '0;
`ifdef UART_PARITY_EN
                        tx_state_n = PARITY;
`else
                        tx_state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                dout = ^tx_buf;
                if (tx_end) tx_state_n = STOP;
            end
`endif
            STOP: if (tx_end) begin
                tx_bit_n = tx_bit + 1'b1;
                if (tx_bit == STOP_LAST) begin
                    tx_bit_n   = '0;
                    tx_state_n = IDLE;
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    // Synchroniser resets high so a reset never looks like a start edge.
    logic din_s1, din_s2, din_prev;
    always_ff @(posedge clk) begin
        if (reset) begin
            din_s1   <= 1'b1;
            din_s2   <= 1'b1;
            din_prev <= 1'b1;
        end else begin
            din_s1   <= din;
            din_s2   <= din_s1;
            din_prev <= din_s2;
        end
    end

    state_t                rx_state, rx_state_n;
    logic [CW-1:0]         rx_cnt, rx_cnt_n;
    logic [2:0]            rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0]  rx_shift;
    logic                  rx_end, rx_shift_en, rx_stop_chk, par_bad;
`ifdef UART_PARITY_EN
    logic                  rx_par_chk, rx_par_bad;
    assign par_bad = rx_par_bad;
`else
    assign par_bad = 1'b0;
`endif

    assign rx_end = (rx_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
        end
    end

    // Only a 1->0 edge arms reception, so a held break line yields a single frame error.
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_bit_n    = rx_bit;
        rx_shift_en = 1'b0;
        rx_stop_chk = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_chk  = 1'b0;
`endif
        case (rx_state)
            IDLE: if (din_prev && !din_s2) begin
                rx_state_n = START;
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
            end
            START: begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = din_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                rx_cnt_n = rx_end ? '0 : rx_cnt + 1'b1;
                if (rx_end) begin
                    rx_shift_en = 1'b1;
                    rx_bit_n    = rx_bit + 1'b1;
                    if (rx_bit == DATA_LAST) begin
                        rx_bit_n = '0;
`ifdef UART_PARITY_EN
                        rx_state_n = PARITY;
`else
                        rx_state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                rx_cnt_n = rx_end ? '0 : rx_cnt + 1'b1;
                if (rx_end) begin
                    rx_par_chk = 1'b1;
                    rx_state_n = STOP;
                end
            end
`endif
            STOP: begin
                rx_cnt_n = rx_end ? '0 : rx_cnt + 1'b1;
                if (rx_end) begin
                    rx_stop_chk = 1'b1;
                    rx_state_n  = IDLE;
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_par_err   <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad   <= 1'b0;
`endif
        end else begin
            rx_frame_err <= 1'b0;
            rx_par_err   <= 1'b0;
            rx_overrun   <= 1'b0;
            if (rx_shift_en) rx_shift <= {din_s2, rx_shift[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
            if (rx_par_chk) rx_par_bad <= din_s2 ^ (^rx_shift);
            if (rx_stop_chk) rx_par_err <= rx_par_bad;
`endif
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (rx_stop_chk) begin
                if (!din_s2) begin
                    rx_frame_err <= 1'b1;
                end else if (!par_bad) begin
                    if (rx_valid && !rx_ready) begin
                        rx_overrun <= 1'b1;
                    end else begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// Directed plus randomized bench for uart_transceiver (default build, no parity), short bit period.
module tb_uart_transceiver;
  localparam int CD = 16;
  localparam int DB = 8;
  localparam int SB = 1;
  localparam int NB = 1 + DB + SB;
  localparam int F  = NB * CD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b1;
  logic       dout;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_frame_err, rx_par_err, rx_overrun;

  int total = 0;
  int bad = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_ovr = 0;
  logic [7:0] exp_q[$];

  always #1 clk = ~clk;

  uart_transceiver #(.CLK_DIV(CD), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .clk(clk), .reset(reset), .din(din), .dout(dout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_par_err(rx_par_err), .rx_overrun(rx_overrun)
  );

  // Error pulses are counted once per high cycle.
  always @(negedge clk) begin
    if (rx_frame_err === 1'b1) n_ferr++;
    if (rx_par_err === 1'b1) n_perr++;
    if (rx_overrun === 1'b1) n_ovr++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line level expected during bit slot j of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= DB) return b[j-1];
    return 1'b1;
  endfunction

  task automatic send_rx(input logic [7:0] b, input logic stopv, input int hold);
    din = 1'b0;
    cyc(CD);
    for (int i = 0; i < DB; i++) begin
      din = b[i];
      cyc(CD);
    end
    din = stopv;
    cyc(CD + hold);
    din = 1'b1;
  endtask

  task automatic rx_expect(input logic [7:0] b, input string tag);
    int w = 0;
    while (rx_valid !== 1'b1 && w < 2 * CD) begin
      cyc(1);
      w++;
    end
    check({tag, "_valid"}, rx_valid, 1'b1);
    check({tag, "_data"}, rx_data, b);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    check({tag, "_taken"}, rx_valid, 1'b0);
  endtask

  task automatic tx_start(input logic [7:0] b);
    int w = 0;
    while (tx_ready !== 1'b1 && w < 2 * F) begin
      cyc(1);
      w++;
    end
    check("tx_ready_wait", tx_ready, 1'b1);
    tx_data = b;
    tx_valid = 1'b1;
    exp_q.push_back(b);
    cyc(1);
  endtask

  // Called on the first negedge after the accepting edge; checks every cycle of the frame.
  task automatic watch_tx(input string tag);
    logic [7:0]    b;
    logic [NB-1:0] obs, expf;
    int            mism, ready_hi;
    b = exp_q.pop_front();
    obs = '0;
    mism = 0;
    ready_hi = 0;
    for (int j = 0; j < NB; j++) expf[j] = exp_bit(b, j);
    for (int k = 0; k < F; k++) begin
      if (dout !== exp_bit(b, k / CD)) mism++;
      if (k % CD == CD / 2) obs[k / CD] = dout;
      if (tx_ready !== 1'b0) ready_hi++;
      if (k == F / 2) tx_data = ~b;
      if (k == F / 2 + 2) tx_data = b;
      cyc(1);
    end
    check({tag, "_frame"}, obs, expf);
    check({tag, "_cycle_mism"}, mism, 0);
    check({tag, "_busy_ready"}, ready_hi, 0);
    check({tag, "_ready_after"}, tx_ready, 1'b1);
    check({tag, "_idle_line"}, dout, 1'b1);
  endtask

  initial begin
    int f0, p0, o0;
    cyc(3);
    check("rst_dout", dout, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_err", {rx_frame_err, rx_par_err, rx_overrun}, 3'b000);
    reset = 1'b0;
    cyc(2);

    // byte 8'h63 held unconsumed, then 8'h8E overruns it
    f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    send_rx(8'h63, 1'b1, 0);
    cyc(4);
    check("rx63_valid", rx_valid, 1'b1);
    check("rx63_data", rx_data, 8'h63);
    check("rx63_no_err", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
    cyc(400);
    o0 = n_ovr;
    send_rx(8'h8E, 1'b1, 0);
    cyc(4);
    check("ovr_pulse", n_ovr - o0, 1);
    check("ovr_keep_data", rx_data, 8'h63);
    check("ovr_keep_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    check("ovr_consumed", rx_valid, 1'b0);
    send_rx(8'h8E, 1'b1, 0);
    rx_expect(8'h8E, "rx8e");

    // 8'hA5 held valid across two back-to-back frames, tx_data disturbed mid-frame
    tx_start(8'hA5);
    exp_q.push_back(8'hA5);
    watch_tx("txa5_f1");
    cyc(1);
    tx_valid = 1'b0;
    watch_tx("txa5_f2");

    // glitch, frame error, break, then recovery
    f0 = n_ferr;
    din = 1'b0;
    cyc(CD / 4);
    din = 1'b1;
    cyc(3 * CD);
    check("glitch_no_valid", rx_valid, 1'b0);
    check("glitch_no_ferr", n_ferr - f0, 0);
    f0 = n_ferr;
    send_rx(8'($urandom_range(0, 255)), 1'b0, 0);
    cyc(4);
    check("ferr_pulse", n_ferr - f0, 1);
    check("ferr_no_valid", rx_valid, 1'b0);
    f0 = n_ferr;
    send_rx(8'h00, 1'b0, 5 * CD);
    cyc(4);
    check("break_one_ferr", n_ferr - f0, 1);
    check("break_no_valid", rx_valid, 1'b0);
    cyc(CD);
    send_rx(8'h3A, 1'b1, 0);
    rx_expect(8'h3A, "rx_after_break");

    // random traffic in both directions at once
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [7:0] rb;
          logic       st;
          int         fr;
          rb = 8'($urandom_range(0, 255));
          st = ($urandom_range(0, 4) != 0);
          fr = n_ferr;
          cyc($urandom_range(1, 30));
          send_rx(rb, st, 0);
          if (st) begin
            rx_expect(rb, "rx_rand");
          end else begin
            cyc(4);
            check("rx_rand_ferr", n_ferr - fr, 1);
            check("rx_rand_no_valid", rx_valid, 1'b0);
          end
        end
      end
      begin
        for (int i = 0; i < 10; i++) begin
          logic [7:0] tb_b;
          tb_b = 8'($urandom_range(0, 255));
          cyc($urandom_range(0, 20));
          tx_start(tb_b);
          tx_valid = 1'b0;
          watch_tx("tx_rand");
        end
      end
    join
    check("rand_no_par_err", n_perr, 0);

    // reset in the middle of a TX frame and an RX frame
    tx_start(8'h3C);
    tx_valid = 1'b0;
    f0 = n_ferr;
    din = 1'b0;
    cyc(CD);
    din = 1'b1;
    cyc(8);
    check("pre_rst_dout_low", dout, 1'b0);
    reset = 1'b1;
    cyc(1);
    check("midrst_dout", dout, 1'b1);
    check("midrst_tx_ready", tx_ready, 1'b1);
    check("midrst_rx_valid", rx_valid, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    cyc(2 * F);
    check("post_rst_no_valid", rx_valid, 1'b0);
    check("post_rst_no_ferr", n_ferr - f0, 0);
    tx_start(8'h5A);
    tx_valid = 1'b0;
    watch_tx("tx_post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
